// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed six-digit 7-segment scanner with per-frame
//             snapshot, inter-digit blanking, BCD decode and HH:MM colon.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] hrm,
    input  logic [6:0] hrl,
    input  logic [6:0] min_m,
    input  logic [6:0] min_l,
    input  logic [6:0] sec_m,
    input  logic [6:0] sec_l,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [5:0] an_out,
    output logic [3:0] digit_bcd,
    output logic       digit_err,
    output logic       frame_start
);

    localparam int                 c_CNT_W      = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] c_LOAD  = 2'd0;
    localparam logic [1:0] c_BLANK = 2'd1;
    localparam logic [1:0] c_ON    = 2'd2;

    localparam logic [6:0] c_SEG_OFF  = 7'h7F;
    localparam logic [6:0] c_SEG_DASH = 7'b1111110;

    logic [1:0]         r_state;
    logic [2:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [6:0]         r_shadow [6];

    logic [4:0]         w_cur_dec;
    logic [4:0]         w_sec_dec;
    logic               w_colon;

    // Returns {illegal, bcd}; illegal patterns report bcd = F.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b0000001: res = 5'h00;
            7'b1001111: res = 5'h01;
            7'b0010010: res = 5'h02;
            7'b0000110: res = 5'h03;
            7'b1001100: res = 5'h04;
            7'b0100100: res = 5'h05;
            7'b0100000: res = 5'h06;
            7'b0001111: res = 5'h07;
            7'b0000000: res = 5'h08;
            7'b0000100: res = 5'h09;
            default:    res = 5'h1F;
        endcase
        return res;
    endfunction

    assign w_cur_dec = f_decode(r_shadow[r_idx]);
    assign w_sec_dec = f_decode(r_shadow[5]);
    // Colon lit on the two separator digits only while the seconds are even.
    assign w_colon   = ((r_idx == 3'd1) || (r_idx == 3'd3)) && !w_sec_dec[4] && !w_sec_dec[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_LOAD;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            for (int i = 0; i < 6; i++) r_shadow[i] <= c_SEG_OFF;
            seg_out     <= c_SEG_OFF;
            an_out      <= 6'h3F;
            dp_out      <= 1'b1;
            digit_bcd   <= 4'h0;
            digit_err   <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            seg_out     <= c_SEG_OFF;
            an_out      <= 6'h3F;
            dp_out      <= 1'b1;
            digit_err   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= c_SEG_OFF;
            an_out      <= 6'h3F;
            dp_out      <= 1'b1;
            digit_err   <= 1'b0;
            frame_start <= 1'b0;
            case (r_state)
                c_LOAD: begin
                    r_shadow[0] <= hrm;
                    r_shadow[1] <= hrl;
                    r_shadow[2] <= min_m;
                    r_shadow[3] <= min_l;
                    r_shadow[4] <= sec_m;
                    r_shadow[5] <= sec_l;
                    frame_start <= 1'b1;
                    // LOAD occupies the first blanking cycle of slot 0.
                    r_cnt       <= c_CNT_ONE;
                    r_state     <= (BLANK_CYCLES == 1) ? c_ON : c_BLANK;
                end
                c_BLANK: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_BLANK_LAST) r_state <= c_ON;
                end
                c_ON: begin
                    an_out    <= ~(6'b000001 << r_idx);
                    seg_out   <= w_cur_dec[4] ? c_SEG_DASH : r_shadow[r_idx];
                    digit_bcd <= w_cur_dec[3:0];
                    digit_err <= w_cur_dec[4];
                    dp_out    <= !w_colon;
                    if (r_cnt == c_SLOT_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd5) begin
                            r_idx   <= 3'd0;
                            r_state <= c_LOAD;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= c_BLANK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= c_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver (frame-position model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 6 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [6:0] in_pat [6];
    logic [6:0] seg_out;
    logic       dp_out;
    logic [5:0] an_out;
    logic [3:0] digit_bcd;
    logic       digit_err;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;
    int kk       = 0;

    seg7_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hrm         (in_pat[0]),
        .hrl         (in_pat[1]),
        .min_m       (in_pat[2]),
        .min_l       (in_pat[3]),
        .sec_m       (in_pat[4]),
        .sec_l       (in_pat[5]),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .digit_bcd   (digit_bcd),
        .digit_err   (digit_err),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int m_decode(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (digit_pat(d) == p) return d;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: position within the frame decides everything.
    int         pos;
    logic [6:0] snap [6];
    logic [6:0] e_seg;
    logic [5:0] e_an;
    logic       e_dp, e_err, e_fs;
    logic [3:0] e_bcd;

    always @(posedge clk) begin
        int slot, c, v, s;
        if (rst) begin
            pos = 0;
            for (int i = 0; i < 6; i++) snap[i] = 7'h7F;
            e_seg = 7'h7F; e_an = 6'h3F; e_dp = 1'b1; e_bcd = 4'h0; e_err = 1'b0; e_fs = 1'b0;
        end else if (!en) begin
            e_seg = 7'h7F; e_an = 6'h3F; e_dp = 1'b1; e_err = 1'b0; e_fs = 1'b0;
        end else begin
            slot = pos / CLK_DIV;
            c    = pos % CLK_DIV;
            if (pos == 0) for (int i = 0; i < 6; i++) snap[i] = in_pat[i];
            e_fs = (pos == 0);
            e_seg = 7'h7F; e_an = 6'h3F; e_dp = 1'b1; e_err = 1'b0;
            if (c >= BLANK_CYCLES) begin
                v = m_decode(snap[slot]);
                s = m_decode(snap[5]);
                e_an = 6'h3F & ~(6'(1) << slot);
                if (v < 0) begin
                    e_seg = 7'b1111110; e_bcd = 4'hF; e_err = 1'b1;
                end else begin
                    e_seg = snap[slot]; e_bcd = 4'(v);
                end
                e_dp = !((slot == 1 || slot == 3) && s >= 0 && (s % 2) == 0);
            end
            pos = (pos + 1) % FRAME;
        end
        #1;
        chk("model_seg", 32'(seg_out), 32'(e_seg));
        chk("model_an", 32'(an_out), 32'(e_an));
        chk("model_dp", 32'(dp_out), 32'(e_dp));
        chk("model_bcd", 32'(digit_bcd), 32'(e_bcd));
        chk("model_err", 32'(digit_err), 32'(e_err));
        chk("model_fs", 32'(frame_start), 32'(e_fs));
    end

    task automatic goto(input int k);
        while (kk < k) begin
            @(negedge clk);
            kk++;
        end
    endtask

    initial begin
        in_pat[0] = digit_pat(1); in_pat[1] = digit_pat(2);
        in_pat[2] = digit_pat(3); in_pat[3] = digit_pat(4);
        in_pat[4] = digit_pat(5); in_pat[5] = digit_pat(6);
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(seg_out), 32'h7F);
        chk("reset_an", 32'(an_out), 32'h3F);
        chk("reset_fs", 32'(frame_start), 32'h0);
        chk("reset_bcd", 32'(digit_bcd), 32'h0);
        rst = 1'b0;

        goto(1);   chk("first_fs", 32'(frame_start), 32'h1);
                   chk("first_an", 32'(an_out), 32'h3F);
        goto(3);   chk("idx0_an", 32'(an_out), 32'h3E);
                   chk("idx0_bcd", 32'(digit_bcd), 32'h1);
        goto(11);  chk("idx1_bcd", 32'(digit_bcd), 32'h2);
                   chk("idx1_colon", 32'(dp_out), 32'h0);
        goto(20);  in_pat[3] = digit_pat(5);
        goto(27);  chk("tear_old", 32'(digit_bcd), 32'h4);
                   chk("idx3_an", 32'(an_out), 32'h37);
        goto(48);  chk("period_pre", 32'(frame_start), 32'h0);
        goto(49);  chk("period_fs", 32'(frame_start), 32'h1);
        goto(75);  chk("tear_new", 32'(digit_bcd), 32'h5);

        goto(90);  in_pat[5] = digit_pat(7); in_pat[4] = 7'h7F;
        goto(107); chk("odd_colon1", 32'(dp_out), 32'h1);
        goto(123); chk("odd_colon3", 32'(dp_out), 32'h1);
        goto(131); chk("illegal_seg", 32'(seg_out), 32'h7E);
                   chk("illegal_bcd", 32'(digit_bcd), 32'hF);
                   chk("illegal_err", 32'(digit_err), 32'h1);
        goto(137); chk("blank_hold_bcd", 32'(digit_bcd), 32'hF);
                   chk("blank_err", 32'(digit_err), 32'h0);
        goto(139); chk("idx5_bcd", 32'(digit_bcd), 32'h7);
        goto(140); in_pat[4] = digit_pat(5); in_pat[5] = digit_pat(6);

        goto(172); chk("prefreeze_an", 32'(an_out), 32'h37);
        en = 1'b0;
        goto(173); chk("freeze_an", 32'(an_out), 32'h3F);
                   chk("freeze_seg", 32'(seg_out), 32'h7F);
        goto(191); chk("freeze_bcd", 32'(digit_bcd), 32'h5);
                   chk("freeze_dp", 32'(dp_out), 32'h1);
        goto(192); en = 1'b1;
        goto(193); chk("resume_an", 32'(an_out), 32'h37);
                   chk("resume_dp", 32'(dp_out), 32'h0);
        goto(212); chk("stretch_pre", 32'(frame_start), 32'h0);
        goto(213); chk("stretch_fs", 32'(frame_start), 32'h1);

        goto(246); rst = 1'b1;
        goto(247); chk("midrst_an", 32'(an_out), 32'h3F);
                   chk("midrst_seg", 32'(seg_out), 32'h7F);
                   chk("midrst_bcd", 32'(digit_bcd), 32'h0);
        goto(248); rst = 1'b0;
        goto(249); chk("postrst_fs", 32'(frame_start), 32'h1);
        goto(251); chk("postrst_an", 32'(an_out), 32'h3E);
                   chk("postrst_bcd", 32'(digit_bcd), 32'h1);
        goto(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
